// File: rtl/barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter_pkg
// Description : Shared definitions for the ARM data-processing shifter.
//               Provides the shift-type and shiftee-select encodings, the
//               decoded-amount record, and a 32-bit rotate helper.
// Revision    : 1.0  initial release
// ============================================================================
package barrel_shifter_pkg;

  // Data-processing shift types, as encoded in the instruction.
  localparam logic [1:0] SHIFT_LSL = 2'd0;
  localparam logic [1:0] SHIFT_LSR = 2'd1;
  localparam logic [1:0] SHIFT_ASR = 2'd2;
  localparam logic [1:0] SHIFT_ROR = 2'd3;

  // Shiftee multiplexer selects that feed this block.
  localparam logic [1:0] IMMED_8_SEL  = 2'd0;
  localparam logic [1:0] RM_SEL       = 2'd1;
  localparam logic [1:0] IMMED_32_SEL = 2'd2;

  // Where the shifter carry comes from.
  typedef enum logic [1:0] {
    CSEL_CIN  = 2'd0,  // CPSR C passes through
    CSEL_ZERO = 2'd1,  // constant 0 (shift of more than 32)
    CSEL_BIT  = 2'd2   // a bit of the shiftee, indexed by carry_idx
  } carry_sel_e;

  // Decoded amount and special-case flags, registered in stage 1.
  typedef struct packed {
    logic [4:0] amt;         // effective shift amount for the normal path
    logic       pass;        // result is the shiftee unchanged
    logic       force_zero;  // result is all zeros
    logic       force_sign;  // result is all copies of shiftee[31]
    logic       rrx;         // rotate right by one through carry
    carry_sel_e carry_sel;
    logic [4:0] carry_idx;   // shiftee bit used when carry_sel is CSEL_BIT
  } shift_dec_t;

  // Rotate right by 0..31.
  function automatic logic [31:0] rotr32(input logic [31:0] v, input logic [4:0] r);
    logic [63:0] dbl;
    dbl = {v, v} >> r;
    return dbl[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_amount_decode.sv
`default_nettype none
// ============================================================================
// Module      : shift_amount_decode
// Description : Combinational decode of the shift type and amount into an
//               effective 5-bit amount plus special-case flags.
//               Ports:
//                 shift_type  in  2  LSL/LSR/ASR/ROR
//                 shift_amt   in  8  immediate uses [4:0], register uses [7:0]
//                 amt_is_reg  in  1  selects register-amount semantics
//                 dec         out    decoded amount, flags, carry source
// Revision    : 1.0  initial release
// ============================================================================
module shift_amount_decode
  import barrel_shifter_pkg::*;
(
  input  logic [1:0] shift_type,
  input  logic [7:0] shift_amt,
  input  logic       amt_is_reg,
  output shift_dec_t dec
);

  logic [4:0] n5;
  logic       ge32;

  always_comb begin
    n5   = shift_amt[4:0];
    ge32 = |shift_amt[7:5];
    dec  = '0;
    dec.carry_sel = CSEL_CIN;

    if (!amt_is_reg) begin
      if (n5 == 5'd0) begin
        // An immediate of zero re-encodes LSR/ASR #32 and RRX.
        unique case (shift_type)
          SHIFT_LSL: dec.pass = 1'b1;
          SHIFT_LSR: begin
            dec.force_zero = 1'b1;
            dec.carry_sel  = CSEL_BIT;
            dec.carry_idx  = 5'd31;
          end
          SHIFT_ASR: begin
            dec.force_sign = 1'b1;
            dec.carry_sel  = CSEL_BIT;
            dec.carry_idx  = 5'd31;
          end
          default: begin
            dec.rrx       = 1'b1;
            dec.carry_sel = CSEL_BIT;
            dec.carry_idx = 5'd0;
          end
        endcase
      end else begin
        dec.amt       = n5;
        dec.carry_sel = CSEL_BIT;
        // LSL carries out bit 32-n, which is -n modulo 32.
        dec.carry_idx = (shift_type == SHIFT_LSL) ? (5'd0 - n5) : (n5 - 5'd1);
      end
    end else if (shift_amt == 8'd0) begin
      dec.pass = 1'b1;
    end else begin
      unique case (shift_type)
        SHIFT_LSL: begin
          if (!ge32) begin
            dec.amt       = n5;
            dec.carry_sel = CSEL_BIT;
            dec.carry_idx = 5'd0 - n5;
          end else if (shift_amt == 8'd32) begin
            dec.force_zero = 1'b1;
            dec.carry_sel  = CSEL_BIT;
            dec.carry_idx  = 5'd0;
          end else begin
            dec.force_zero = 1'b1;
            dec.carry_sel  = CSEL_ZERO;
          end
        end
        SHIFT_LSR: begin
          if (!ge32) begin
            dec.amt       = n5;
            dec.carry_sel = CSEL_BIT;
            dec.carry_idx = n5 - 5'd1;
          end else if (shift_amt == 8'd32) begin
            dec.force_zero = 1'b1;
            dec.carry_sel  = CSEL_BIT;
            dec.carry_idx  = 5'd31;
          end else begin
            dec.force_zero = 1'b1;
            dec.carry_sel  = CSEL_ZERO;
          end
        end
        SHIFT_ASR: begin
          dec.carry_sel = CSEL_BIT;
          if (!ge32) begin
            dec.amt       = n5;
            dec.carry_idx = n5 - 5'd1;
          end else begin
            dec.force_sign = 1'b1;
            dec.carry_idx  = 5'd31;
          end
        end
        default: begin
          // Register ROR only looks at the low five bits of the amount.
          dec.carry_sel = CSEL_BIT;
          if (n5 == 5'd0) begin
            dec.pass      = 1'b1;
            dec.carry_idx = 5'd31;
          end else begin
            dec.amt       = n5;
            dec.carry_idx = n5 - 5'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter
// Description : Two-stage pipelined ARM data-processing shifter with a
//               valid/ready interface and flush.
//               Ports:
//                 clk, reset          clock, synchronous active-high reset
//                 flush               drop everything in flight
//                 in_valid/in_ready   request handshake
//                 shiftee, shift_type, amt_is_reg, shift_amt, carry_in
//                 out_valid/out_ready result handshake
//                 shifter_operand, shifter_carry_out  registered results
// Revision    : 1.0  initial release
// ============================================================================
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shiftee,
  input  logic [1:0]       shift_type,
  input  logic             amt_is_reg,
  input  logic [7:0]       shift_amt,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shifter_operand,
  output logic             shifter_carry_out
);

  shift_dec_t dec;

  logic             s1_valid_q,   s1_valid_d;
  logic [WIDTH-1:0] s1_shiftee_q, s1_shiftee_d;
  logic [1:0]       s1_type_q,    s1_type_d;
  logic             s1_cin_q,     s1_cin_d;
  shift_dec_t       s1_dec_q,     s1_dec_d;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] operand_q,    operand_d;
  logic             carry_q,      carry_d;

  logic             s1_advance;
  logic             s2_advance;

  logic [4:0]       rot_amt;
  logic [WIDTH-1:0] rot;
  logic [WIDTH-1:0] lsr_mask;
  logic [WIDTH-1:0] lsl_mask;
  logic [WIDTH-1:0] shift_result;
  logic             shift_carry;

  shift_amount_decode u_decode (
    .shift_type (shift_type),
    .shift_amt  (shift_amt),
    .amt_is_reg (amt_is_reg),
    .dec        (dec)
  );

  // Shift network: every normal shift is one right-rotate plus a mask.
  // LSL by n is a right-rotate by 32-n with the low n bits cleared.
  always_comb begin
    rot_amt  = (s1_type_q == SHIFT_LSL) ? (5'd0 - s1_dec_q.amt) : s1_dec_q.amt;
    rot      = rotr32(s1_shiftee_q, rot_amt);
    lsr_mask = {WIDTH{1'b1}} >> s1_dec_q.amt;
    lsl_mask = {WIDTH{1'b1}} << s1_dec_q.amt;

    if (s1_dec_q.pass) begin
      shift_result = s1_shiftee_q;
    end else if (s1_dec_q.force_zero) begin
      shift_result = '0;
    end else if (s1_dec_q.force_sign) begin
      shift_result = {WIDTH{s1_shiftee_q[WIDTH-1]}};
    end else if (s1_dec_q.rrx) begin
      shift_result = {s1_cin_q, s1_shiftee_q[WIDTH-1:1]};
    end else begin
      unique case (s1_type_q)
        SHIFT_LSL: shift_result = rot & lsl_mask;
        SHIFT_LSR: shift_result = rot & lsr_mask;
        SHIFT_ASR: shift_result = (rot & lsr_mask) |
                                  (~lsr_mask & {WIDTH{s1_shiftee_q[WIDTH-1]}});
        default:   shift_result = rot;
      endcase
    end

    unique case (s1_dec_q.carry_sel)
      CSEL_ZERO: shift_carry = 1'b0;
      CSEL_BIT:  shift_carry = s1_shiftee_q[s1_dec_q.carry_idx];
      default:   shift_carry = s1_cin_q;
    endcase
  end

  // Handshake and next-state for both stages.
  always_comb begin
    s2_advance = !out_valid_q || out_ready;
    s1_advance = !s1_valid_q || s2_advance;
    in_ready   = !reset && s1_advance;

    s1_valid_d   = s1_valid_q;
    s1_shiftee_d = s1_shiftee_q;
    s1_type_d    = s1_type_q;
    s1_cin_d     = s1_cin_q;
    s1_dec_d     = s1_dec_q;
    out_valid_d  = out_valid_q;
    operand_d    = operand_q;
    carry_d      = carry_q;

    if (s1_advance) begin
      s1_valid_d = in_valid && !flush;
      if (in_valid && !flush) begin
        s1_shiftee_d = shiftee;
        s1_type_d    = shift_type;
        s1_cin_d     = carry_in;
        s1_dec_d     = dec;
      end
    end

    // Output data only changes when a new result moves in, so it stays
    // stable under backpressure.
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        operand_d = shift_result;
        carry_d   = shift_carry;
      end
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_shiftee_q <= '0;
      s1_type_q    <= '0;
      s1_cin_q     <= 1'b0;
      s1_dec_q     <= '0;
      out_valid_q  <= 1'b0;
      operand_q    <= '0;
      carry_q      <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_shiftee_q <= s1_shiftee_d;
      s1_type_q    <= s1_type_d;
      s1_cin_q     <= s1_cin_d;
      s1_dec_q     <= s1_dec_d;
      out_valid_q  <= out_valid_d;
      operand_q    <= operand_d;
      carry_q      <= carry_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign shifter_operand   = operand_q;
  assign shifter_carry_out = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shifter
// Description : Scoreboard bench for barrel_shifter using directed vectors
//               with hand-computed results.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_barrel_shifter;

  localparam int NV = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] shiftee;
  logic [1:0]  shift_type;
  logic        amt_is_reg;
  logic [7:0]  shift_amt;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shifter_operand;
  logic        shifter_carry_out;

  always #5 clk = ~clk;

  barrel_shifter #(.WIDTH(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .shiftee           (shiftee),
    .shift_type        (shift_type),
    .amt_is_reg        (amt_is_reg),
    .shift_amt         (shift_amt),
    .carry_in          (carry_in),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .shifter_operand   (shifter_operand),
    .shifter_carry_out (shifter_carry_out)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          id;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int ready_mode = 0;   // 0: out_ready=1, 1: pseudo-random, 2: out_ready=0
  int accept_cycles = 0;

  logic [1:0]  tv_type [NV];
  logic        tv_reg  [NV];
  logic [7:0]  tv_amt  [NV];
  logic [31:0] tv_v    [NV];
  logic        tv_c    [NV];
  logic [31:0] tv_res  [NV];
  logic        tv_co   [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic setv(input int i, input logic [1:0] t, input logic r, input logic [7:0] a,
                      input logic [31:0] v, input logic c, input logic [31:0] res, input logic co);
    tv_type[i] = t; tv_reg[i] = r; tv_amt[i] = a; tv_v[i] = v;
    tv_c[i] = c; tv_res[i] = res; tv_co[i] = co;
  endtask

  task automatic init_vectors();
    //      idx type  reg amt    shiftee        C  result         carry
    setv(0,  2'd0, 0, 8'd4,   32'hF000_000F, 0, 32'h0000_00F0, 1); // LSL #4
    setv(1,  2'd1, 0, 8'd0,   32'h8000_0001, 0, 32'h0000_0000, 1); // LSR #32
    setv(2,  2'd3, 0, 8'd0,   32'h0000_0003, 1, 32'h8000_0001, 1); // RRX
    setv(3,  2'd0, 1, 8'd32,  32'h0000_0001, 0, 32'h0000_0000, 1); // LSL Rs=32
    setv(4,  2'd0, 1, 8'd33,  32'h0000_0001, 1, 32'h0000_0000, 0); // LSL Rs=33
    setv(5,  2'd0, 1, 8'd0,   32'h0000_0001, 1, 32'h0000_0001, 1); // LSL Rs=0
    setv(6,  2'd2, 1, 8'd40,  32'h8000_0000, 0, 32'hFFFF_FFFF, 1); // ASR Rs=40
    setv(7,  2'd3, 1, 8'h20,  32'h8000_0000, 0, 32'h8000_0000, 1); // ROR Rs=32
    setv(8,  2'd2, 0, 8'd0,   32'h8000_0000, 0, 32'hFFFF_FFFF, 1); // ASR #32
    setv(9,  2'd1, 0, 8'hE4,  32'h0000_00F8, 0, 32'h0000_000F, 1); // LSR #4, junk upper bits
    setv(10, 2'd2, 0, 8'd8,   32'h8000_0080, 0, 32'hFF80_0000, 1); // ASR #8
    setv(11, 2'd3, 0, 8'd4,   32'h1234_5678, 0, 32'h8123_4567, 1); // ROR #4
    setv(12, 2'd3, 1, 8'h24,  32'h1234_5678, 0, 32'h8123_4567, 1); // ROR Rs=36
    setv(13, 2'd1, 1, 8'd32,  32'h8000_0000, 0, 32'h0000_0000, 1); // LSR Rs=32
    setv(14, 2'd1, 1, 8'hC8,  32'hFFFF_FFFF, 1, 32'h0000_0000, 0); // LSR Rs=200
    setv(15, 2'd0, 0, 8'd31,  32'h0000_0003, 0, 32'h8000_0000, 1); // LSL #31
    setv(16, 2'd2, 1, 8'd0,   32'h1234_5678, 0, 32'h1234_5678, 0); // ASR Rs=0
    setv(17, 2'd0, 1, 8'd1,   32'h8000_0001, 0, 32'h0000_0002, 1); // LSL Rs=1
    setv(18, 2'd1, 0, 8'd31,  32'h8000_0000, 0, 32'h0000_0001, 0); // LSR #31
    setv(19, 2'd2, 1, 8'd31,  32'h7FFF_FFFF, 1, 32'h0000_0000, 1); // ASR Rs=31
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  // Present vector i until accepted; inputs change #1 after posedge.
  task automatic send(input int i);
    int  guard;
    bit  acc;
    exp_t e;
    guard = 0;
    acc   = 1'b0;
    shiftee    = tv_v[i];
    shift_type = tv_type[i];
    amt_is_reg = tv_reg[i];
    shift_amt  = tv_amt[i];
    carry_in   = tv_c[i];
    in_valid   = 1'b1;
    while (!acc) begin
      drive_ready();
      @(negedge clk);
      if (in_ready) begin
        acc   = 1'b1;
        e.res = tv_res[i];
        e.c   = tv_co[i];
        e.id  = i;
        sb.push_back(e);
      end
      accept_cycles++;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 100) begin
        checks++;
        failures++;
        $display("FAIL send_timeout vector=%0d actual=not_accepted required=accepted", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    ready_mode = 0;
    out_ready  = 1'b1;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that
  // a stalled output holds its data.
  initial begin
    logic        prev_stall;
    logic [31:0] held_op;
    logic        held_c;
    exp_t        e;
    prev_stall = 1'b0;
    held_op    = '0;
    held_c     = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_valid",   {31'b0, out_valid}, 32'd1);
        chk("stall_operand", shifter_operand, held_op);
        chk("stall_carry",   {31'b0, shifter_carry_out}, {31'b0, held_c});
      end
      prev_stall = out_valid && !out_ready && !flush && !reset;
      held_op    = shifter_operand;
      held_c     = shifter_carry_out;
      if (out_valid && out_ready && !reset) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%08h required=no_output", shifter_operand);
        end else begin
          e = sb.pop_front();
          chk($sformatf("operand_v%0d", e.id), shifter_operand, e.res);
          chk($sformatf("carry_v%0d", e.id), {31'b0, shifter_carry_out}, {31'b0, e.c});
        end
      end
    end
  end

  initial begin
    init_vectors();
    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    shiftee    = '0;
    shift_type = '0;
    amt_is_reg = 1'b0;
    shift_amt  = '0;
    carry_in   = 1'b0;
    out_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'b0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_operand",   shifter_operand, 32'd0);
    chk("reset_carry",     {31'b0, shifter_carry_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency from an empty pipe
    ready_mode = 0;
    send(0);
    @(negedge clk);
    chk("latency_edge_k", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_edge_k1", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Full-rate stream: every request accepted on its first cycle
    accept_cycles = 0;
    for (int i = 0; i < NV; i++) send(i);
    chk("throughput_cycles", 32'(accept_cycles), 32'(NV));
    drain();

    // Stream with pseudo-random backpressure
    ready_mode = 1;
    for (int i = 0; i < NV; i++) send(i);
    drain();

    // Flush with a full, stalled pipeline and a new request present
    ready_mode = 2;
    send(6);
    send(7);
    out_ready  = 1'b0;
    shiftee    = tv_v[11];
    shift_type = tv_type[11];
    amt_is_reg = tv_reg[11];
    shift_amt  = tv_amt[11];
    carry_in   = tv_c[11];
    in_valid   = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    ready_mode = 0;
    out_ready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Flush with an empty pipeline: in_ready high but the request dropped
    shiftee    = tv_v[0];
    shift_type = tv_type[0];
    amt_is_reg = tv_reg[0];
    shift_amt  = tv_amt[0];
    carry_in   = tv_c[0];
    in_valid   = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("flush_empty_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_drop_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-stream with a full, stalled pipeline
    ready_mode = 2;
    send(6);
    send(8);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_operand",   shifter_operand, 32'd0);
    chk("midreset_carry",     {31'b0, shifter_carry_out}, 32'd0);
    chk("midreset_in_ready",  {31'b0, in_ready}, 32'd0);
    reset      = 1'b0;
    ready_mode = 0;
    out_ready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Recovery after reset
    send(12);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barrel_shifter.md
# barrel_shifter

Two-stage pipelined ARM shifter that consumes the 32-bit `shiftee` selected by the shiftee multiplexer. It applies the data-processing shift (LSL/LSR/ASR/ROR/RRX) with full ARM immediate- and register-amount semantics. It produces `shifter_operand` and `shifter_carry_out` for the ALU. It has a valid/ready elastic interface and a flush input for branch and exception redirect.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Only 32 is supported; the parameter documents intent.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `flush`  input  1  kill all in-flight operations.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  stage 1 can accept a request this cycle.
- `shiftee`  input  32  value to shift.
- `shift_type`  input  2  `LSL`=0, `LSR`=1, `ASR`=2, `ROR`=3.
- `amt_is_reg`  input  1  0: immediate amount in `shift_amt[4:0]`; 1: register amount in `shift_amt[7:0]` (Rs[7:0]).
- `shift_amt`  input  8  shift amount.
- `carry_in`  input  1  current CPSR C flag.
- `out_valid`  output  1  result present.
- `out_ready`  input  1  consumer accepts the result.
- `shifter_operand`  output  32  shifted result.
- `shifter_carry_out`  output  1  shifter carry.

## Operation
Amount rules. v = shiftee, C = carry_in, n = amount.
- Immediate, n = 0:
  - LSL: result v, carry C.
  - LSR #32: result 0, carry v[31].
  - ASR #32: result {32{v[31]}}, carry v[31].
  - ROR means RRX: result {C, v[31:1]}, carry v[0].
- Immediate, 1..31: normal shift.
  - Carry for LSL is v[32-n].
  - Carry for LSR, ASR and ROR is v[n-1].
- Register, n = 0: result v, carry C, for every type.
- Register LSL:
  - n < 32: normal shift.
  - n = 32: result 0, carry v[0].
  - n > 32: result 0, carry 0.
- Register LSR:
  - n < 32: normal shift.
  - n = 32: result 0, carry v[31].
  - n > 32: result 0, carry 0.
- Register ASR, n ≥ 32: result {32{v[31]}}, carry v[31].
- Register ROR, n ≠ 0:
  - If n[4:0] = 0: result v, carry v[31].
  - Otherwise rotate by n[4:0]; carry v[n[4:0]-1].

Pipeline.
- Stage 1 registers the request. It also registers the decoded fields: effective 5-bit amount, a pass-through flag, a force-zero flag, a force-sign flag, an RRX flag and the carry-select source.
- Stage 2 performs the shift and carry selection, then registers the outputs.
- Each stage holds a valid bit. A stage advances when it is empty or when the stage after it advances.
  - Stage 2 advances when `!out_valid || out_ready`.
  - `in_ready = !s1_valid || s2_advance`.
- Output data holds stable while `out_valid && !out_ready`.
- `flush`:
  - Clears both valid bits on the edge.
  - A request presented in the same cycle is dropped, so `in_ready` is 1 that cycle but the request is not captured.
- Reset:
  - Clears valid bits, `shifter_operand` and `shifter_carry_out` to 0.
  - Clears all stage-1 registers to 0.
  - `in_ready` is 0 while `reset` is high and 1 in the first cycle after.
- Reset or flush mid-operation: nothing in flight is emitted afterwards.

## Timing
- Latency: request accepted at edge k appears with `out_valid` = 1 after edge k+1, with no backpressure.
- Throughput: one result per cycle with `out_ready` held 1.
- Full pipeline with `out_ready` = 0: `in_ready` = 0. No request is lost or duplicated.
- Simultaneous output acceptance and input accept when full: both stages shift, and `in_ready` = 1.
- Combinational paths to outputs: only `in_ready` depends on `out_ready`. `shifter_operand` and `shifter_carry_out` are registered.

## Structure
- Shared defines header: `SHIFT_LSL`, `SHIFT_LSR`, `SHIFT_ASR`, `SHIFT_ROR`. These sit alongside the existing shiftee-select defines `IMMED_8_SEL`, `RM_SEL`, `IMMED_32_SEL`.
- Sub-module `shift_amount_decode`: combinational stage-1 logic.
  - Inputs: type, amount, `amt_is_reg`.
  - Outputs: effective amount plus special-case flags.
  - Unit-testable on its own.
- Top level: stage registers, shift network (a single 32-bit rotate plus masks) and handshake.

## Test plan
- Immediate cases:
  - LSL #4, v=0xF000_000F, C=0 -> 0x0000_00F0, carry 1.
  - LSR #0, v=0x8000_0001 -> 0x0000_0000, carry 1.
  - RRX, v=0x0000_0003, C=1 -> 0x8000_0001, carry 1.
- Register LSL, v=0x0000_0001:
  - n=32 -> 0, carry 1.
  - n=33 -> 0, carry 0.
  - n=0, C=1 -> 0x0000_0001, carry 1.
- Register ASR, v=0x8000_0000:
  - n=40 -> 0xFFFF_FFFF, carry 1.
  - Register ROR, v=0x8000_0000, n=0x20 -> 0x8000_0000, carry 1.
- Back-to-back stream of 16 random requests with `out_ready` toggled pseudo-randomly:
  - Outputs match a reference model in order.
  - No drops or duplicates.
  - Data is stable while stalled.
- Full pipeline stalled:
  - Assert `flush` with a new request present -> next cycle `out_valid`=0, and the new request is not emitted.
  - Reset asserted mid-stream -> outputs read 0 and `out_valid`=0 at the edge.
